// File: rtl/imem_pkg.sv
// Shared definitions for the instruction ROM: widths, NOP encoding and the
// default program image loaded into the array at elaboration.
package imem_pkg;

    localparam int unsigned IMEM_DATA_W        = 16;
    localparam int unsigned IMEM_ADDR_W        = 16;
    localparam int unsigned IMEM_DEFAULT_DEPTH = 256;
    localparam int unsigned IMEM_IMAGE_LEN     = 9;

    typedef logic [IMEM_DATA_W-1:0] instr_t;
    typedef logic [IMEM_ADDR_W-1:0] iaddr_t;

    localparam instr_t IMEM_NOP = 16'h0000;

    localparam instr_t IMEM_DEFAULT_IMAGE [0:IMEM_IMAGE_LEN-1] = '{
        16'h8001, 16'h8102, 16'h0312, 16'h2413, 16'h4534,
        16'h6045, 16'hA506, 16'hC007, 16'hE000
    };

    // Word beyond the explicit image reads as NOP.
    function automatic instr_t imem_default_word(input iaddr_t idx);
        instr_t word;
        word = IMEM_NOP;
        if (idx < iaddr_t'(IMEM_IMAGE_LEN)) begin
            word = IMEM_DEFAULT_IMAGE[idx[3:0]];
        end
        return word;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage with combinational lookup; out-of-range reads return NOP.
// IMEM_WRITE_PORT_EN adds a synchronous program-load port (otherwise pure ROM).
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEFAULT_DEPTH
) (
`ifdef IMEM_WRITE_PORT_EN
    input  logic                   clock,
    input  logic                   wr_en,
    input  logic [IMEM_ADDR_W-1:0] wr_addr,
    input  logic [IMEM_DATA_W-1:0] wr_data,
`endif
    input  logic [IMEM_ADDR_W-1:0] rd_addr,
    output logic [IMEM_DATA_W-1:0] rd_data
);

    logic in_range;

    // Full-width compare so high address bits never alias onto low words.
    assign in_range = (32'(rd_addr) < DEPTH);

`ifdef IMEM_WRITE_PORT_EN
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    instr_t words [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        instr_t word_q = imem_default_word(IMEM_ADDR_W'(i));

        always_ff @(posedge clock) begin
            if (wr_en && (wr_addr == IMEM_ADDR_W'(i))) begin
                word_q <= wr_data;
            end
        end

        assign words[i] = word_q;
    end

    always_comb begin
        rd_data = IMEM_NOP;
        if (in_range) begin
            rd_data = words[rd_addr[IDX_W-1:0]];
        end
    end
`else
    always_comb begin
        rd_data = IMEM_NOP;
        if (in_range) begin
            rd_data = imem_default_word(rd_addr);
        end
    end
`endif

endmodule

// File: rtl/instruction_memory.sv
// Fetch-side instruction memory: registered 1-cycle read gated by im_enable.
// Optional program-load port enabled by IMEM_WRITE_PORT_EN.
module instruction_memory
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH      = IMEM_DEFAULT_DEPTH,
    parameter int unsigned DATA_WIDTH = IMEM_DATA_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [IMEM_ADDR_W-1:0] address,
    input  logic                   im_enable,
`ifdef IMEM_WRITE_PORT_EN
    input  logic                   wr_en,
    input  logic [IMEM_ADDR_W-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
`endif
    output logic [DATA_WIDTH-1:0]  instruction
);

    instr_t rd_data;

    imem_array #(
        .DEPTH (DEPTH)
    ) u_imem_array (
`ifdef IMEM_WRITE_PORT_EN
        .clock   (clock),
        .wr_en   (wr_en && !reset),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .rd_addr (address),
        .rd_data (rd_data)
    );

    // Disabled fetch issues a registered NOP rather than holding the last word.
    always_ff @(posedge clock) begin
        if (reset) begin
            instruction <= IMEM_NOP;
        end else if (im_enable) begin
            instruction <= rd_data;
        end else begin
            instruction <= IMEM_NOP;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory; write-port cases run only when
// IMEM_WRITE_PORT_EN is defined.
module tb_instruction_memory;

    logic        clock;
    logic        reset;
    logic [15:0] address;
    logic        im_enable;
    logic [15:0] instruction;
`ifdef IMEM_WRITE_PORT_EN
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    instruction_memory dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .im_enable   (im_enable),
`ifdef IMEM_WRITE_PORT_EN
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`endif
        .instruction (instruction)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [15:0] prog [0:8] = '{16'h8001, 16'h8102, 16'h0312, 16'h2413, 16'h4534,
                                16'h6045, 16'hA506, 16'hC007, 16'hE000};

    initial begin
        reset     = 1'b1;
        im_enable = 1'b1;
        address   = 16'h0000;
`ifdef IMEM_WRITE_PORT_EN
        wr_en   = 1'b0;
        wr_addr = 16'h0000;
        wr_data = 16'h0000;
`endif
        #1;

        step();
        check("reset_edge1", instruction, 16'h0000);
        step();
        check("reset_edge2", instruction, 16'h0000);
        reset = 1'b0;
        step();
        check("reset_release", instruction, 16'h8001);

        for (int i = 0; i < 9; i++) begin
            address = 16'(i);
            step();
            check($sformatf("seq_fetch_%0d", i), instruction, prog[i]);
        end

        im_enable = 1'b0;
        address   = 16'h0000;
        step();
        check("disable_nop", instruction, 16'h0000);
        im_enable = 1'b1;
        step();
        check("reenable", instruction, 16'h8001);

        address = 16'h0100;
        step();
        check("oor_0100", instruction, 16'h0000);
        address = 16'hFFFF;
        step();
        check("oor_ffff", instruction, 16'h0000);
        address = 16'h00FF;
        step();
        check("last_word_zero", instruction, 16'h0000);
        address = 16'h0009;
        step();
        check("past_image", instruction, 16'h0000);

        address = 16'h0005;
        step();
        check("mid_fetch5", instruction, 16'h6045);
        reset = 1'b1;
        step();
        check("mid_reset", instruction, 16'h0000);
        reset   = 1'b0;
        address = 16'h0006;
        step();
        check("post_reset6", instruction, 16'hA506);

`ifdef IMEM_WRITE_PORT_EN
        address = 16'h0003;
        wr_en   = 1'b1;
        wr_addr = 16'h0003;
        wr_data = 16'hBEEF;
        step();
        check("wr_read_first", instruction, 16'h2413);
        wr_en = 1'b0;
        step();
        check("wr_new_word", instruction, 16'hBEEF);

        wr_en   = 1'b1;
        wr_addr = 16'h0100;
        wr_data = 16'h1234;
        address = 16'h0000;
        step();
        check("oor_wr_word0", instruction, 16'h8001);
        wr_en   = 1'b0;
        address = 16'h0100;
        step();
        check("oor_wr_0100", instruction, 16'h0000);

        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 16'h0004;
        wr_data = 16'hDEAD;
        step();
        check("wr_in_reset_out", instruction, 16'h0000);
        reset   = 1'b0;
        wr_en   = 1'b0;
        address = 16'h0004;
        step();
        check("wr_blocked_reset", instruction, 16'h4534);

        im_enable = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 16'h0007;
        wr_data   = 16'h5A5A;
        step();
        check("wr_disabled_out", instruction, 16'h0000);
        im_enable = 1'b1;
        wr_en     = 1'b0;
        address   = 16'h0007;
        step();
        check("wr_while_disabled", instruction, 16'h5A5A);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
